conv_7_8_acc_relu: RTL and testbench

Accumulate / bias / requantise stage that sits directly downstream of the conv_7_8 8x16 signed DSP48 multiplier. It consumes the stream of 24-bit signed products, sums TAPS products per output pixel on top of a per-window bias, and scales the sum down to the 16-bit activation format with optional ReLU and saturation. It then presents the result on a valid/ready output port.

---
 rtl/conv_7_8_acc_relu.sv | 131 +++++++++++++
 tb/tb_conv_7_8_acc_relu.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/conv_7_8_acc_relu.sv
// rtl/conv_7_8_acc_relu.sv - accumulate TAPS products on a bias, requantise with optional ReLU
// and saturation, and present the result on a valid/ready port.
module conv_7_8_acc_relu #(
  parameter int DIN_WIDTH  = 24,
  parameter int ACC_WIDTH  = 32,
  parameter int DOUT_WIDTH = 16,
  parameter int TAPS       = 9,
  parameter int SHIFT      = 8
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic [DIN_WIDTH-1:0]  din,
  input  logic                  din_vld,
  output logic                  din_rdy,
  input  logic [ACC_WIDTH-1:0]  bias,
  input  logic                  relu_en,
  output logic [DOUT_WIDTH-1:0] dout,
  output logic                  dout_vld,
  input  logic                  dout_rdy
);

  localparam int TAP_W = (TAPS > 1) ? $clog2(TAPS) : 1;
  localparam logic [TAP_W-1:0] LAST_TAP = TAP_W'(TAPS - 1);

  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
    {{(ACC_WIDTH-DOUT_WIDTH+1){1'b0}}, {(DOUT_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
    {{(ACC_WIDTH-DOUT_WIDTH+1){1'b1}}, {(DOUT_WIDTH-1){1'b0}}};
  localparam logic [DOUT_WIDTH-1:0] DOUT_MAX = {1'b0, {(DOUT_WIDTH-1){1'b1}}};
  localparam logic [DOUT_WIDTH-1:0] DOUT_MIN = {1'b1, {(DOUT_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    S_ACC  = 2'd0,
    S_POST = 2'd1,
    S_OUT  = 2'd2
  } state_t;

  state_t                         state_q, state_d;
  logic [TAP_W-1:0]               tap_cnt_q, tap_cnt_d;
  logic signed [ACC_WIDTH-1:0]    acc_q, acc_d;
  logic                           relu_q, relu_d;
  logic [DOUT_WIDTH-1:0]          dout_q, dout_d;
  logic                           dout_vld_q, dout_vld_d;

  logic signed [ACC_WIDTH-1:0]    din_sext;
  logic signed [ACC_WIDTH-1:0]    shifted;
  logic signed [ACC_WIDTH-1:0]    rectified;
  logic [DOUT_WIDTH-1:0]          sat_val;
  logic                           accept;

  // Ready depends only on state and reset so upstream never sees a combinational loop.
  assign din_rdy  = ap_rst_n && (state_q == S_ACC);
  assign accept   = din_vld && din_rdy;
  assign dout     = dout_q;
  assign dout_vld = dout_vld_q;

  assign din_sext = {{(ACC_WIDTH-DIN_WIDTH){din[DIN_WIDTH-1]}}, din};

  always_comb begin
    shifted   = acc_q >>> SHIFT;
    rectified = (relu_q && shifted < 0) ? '0 : shifted;
    if (rectified > SAT_MAX) begin
      sat_val = DOUT_MAX;
    end else if (rectified < SAT_MIN) begin
      sat_val = DOUT_MIN;
    end else begin
      sat_val = rectified[DOUT_WIDTH-1:0];
    end
  end

  always_comb begin
    state_d    = state_q;
    tap_cnt_d  = tap_cnt_q;
    acc_d      = acc_q;
    relu_d     = relu_q;
    dout_d     = dout_q;
    dout_vld_d = dout_vld_q;
    case (state_q)
      S_ACC: begin
        if (accept) begin
          // First tap of a window restarts the sum from the bias.
          if (tap_cnt_q == '0) begin
            acc_d  = $signed(bias) + din_sext;
            relu_d = relu_en;
          end else begin
            acc_d = acc_q + din_sext;
          end
          if (tap_cnt_q == LAST_TAP) begin
            tap_cnt_d = '0;
            state_d   = S_POST;
          end else begin
            tap_cnt_d = tap_cnt_q + TAP_W'(1);
          end
        end
      end
      S_POST: begin
        dout_d     = sat_val;
        dout_vld_d = 1'b1;
        state_d    = S_OUT;
      end
      S_OUT: begin
        if (dout_vld_q && dout_rdy) begin
          dout_vld_d = 1'b0;
          state_d    = S_ACC;
        end
      end
      default: begin
        state_d = S_ACC;
      end
    endcase
  end

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      state_q    <= S_ACC;
      tap_cnt_q  <= '0;
      acc_q      <= '0;
      relu_q     <= 1'b0;
      dout_q     <= '0;
      dout_vld_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      tap_cnt_q  <= tap_cnt_d;
      acc_q      <= acc_d;
      relu_q     <= relu_d;
      dout_q     <= dout_d;
      dout_vld_q <= dout_vld_d;
    end
  end

endmodule

// File: tb/tb_conv_7_8_acc_relu.sv
// tb/tb_conv_7_8_acc_relu.sv - directed self-checking bench for conv_7_8_acc_relu
module tb_conv_7_8_acc_relu;

  logic        ap_clk = 1'b0;
  logic        ap_rst_n;
  logic [23:0] din;
  logic        din_vld;
  logic        din_rdy;
  logic [31:0] bias;
  logic        relu_en;
  logic [15:0] dout;
  logic        dout_vld;
  logic        dout_rdy;

  int checks = 0;
  int errors = 0;

  conv_7_8_acc_relu dut (
    .ap_clk   (ap_clk),
    .ap_rst_n (ap_rst_n),
    .din      (din),
    .din_vld  (din_vld),
    .din_rdy  (din_rdy),
    .bias     (bias),
    .relu_en  (relu_en),
    .dout     (dout),
    .dout_vld (dout_vld),
    .dout_rdy (dout_rdy)
  );

  always #5 ap_clk = ~ap_clk;

  task automatic step();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one tap and hold it until the edge that accepts it; din_vld stays high afterwards.
  task automatic feed(input logic [23:0] v, input logic [31:0] b, input logic r);
    int g;
    din     = v;
    bias    = b;
    relu_en = r;
    din_vld = 1'b1;
    g = 0;
    while (!din_rdy && g < 20) begin
      step();
      g++;
    end
    if (g >= 20) chk("feed_timeout", 32'd1, 32'd0);
    step();
  endtask

  task automatic window(input logic [23:0] v, input logic [31:0] b, input logic r);
    for (int i = 0; i < 9; i++) feed(v, b, r);
    din_vld = 1'b0;
  endtask

  // Wait for the result, check it, then complete the handshake.
  task automatic take(input string tag, input logic [15:0] exp);
    int g;
    g = 0;
    while (!dout_vld && g < 20) begin
      step();
      g++;
    end
    chk({tag, "_vld"}, {31'd0, dout_vld}, 32'd1);
    chk(tag, {16'd0, dout}, {16'd0, exp});
    dout_rdy = 1'b1;
    step();
  endtask

  initial begin
    ap_rst_n = 1'b0;
    din      = '0;
    din_vld  = 1'b0;
    bias     = '0;
    relu_en  = 1'b0;
    dout_rdy = 1'b1;
    step();
    step();
    chk("rst_dout", {16'd0, dout}, 32'd0);
    chk("rst_dout_vld", {31'd0, dout_vld}, 32'd0);
    chk("rst_din_rdy", {31'd0, din_rdy}, 32'd0);
    ap_rst_n = 1'b1;
    #1;
    chk("post_rst_din_rdy", {31'd0, din_rdy}, 32'd1);

    // Basic sum with exact cycle timing around the output.
    for (int i = 0; i < 9; i++) feed(24'd256, 32'd0, 1'b0);
    din_vld = 1'b0;
    chk("basic_post_vld", {31'd0, dout_vld}, 32'd0);
    chk("basic_post_rdy", {31'd0, din_rdy}, 32'd0);
    step();
    chk("basic_out_vld", {31'd0, dout_vld}, 32'd1);
    chk("basic_out_dout", {16'd0, dout}, 32'd9);
    chk("basic_out_rdy", {31'd0, din_rdy}, 32'd0);
    step();
    chk("basic_hs_vld", {31'd0, dout_vld}, 32'd0);
    chk("basic_hs_rdy", {31'd0, din_rdy}, 32'd1);
    chk("basic_hs_dout_kept", {16'd0, dout}, 32'd9);

    // Negative and ReLU; relu_en only counts on the first tap.
    window(-24'sd256, 32'd0, 1'b0);
    take("neg", 16'hFFF7);
    feed(-24'sd256, 32'd0, 1'b1);
    for (int i = 0; i < 8; i++) feed(-24'sd256, 32'd0, 1'b0);
    din_vld = 1'b0;
    take("relu", 16'h0000);
    feed(-24'sd256, 32'd0, 1'b0);
    for (int i = 0; i < 8; i++) feed(-24'sd256, 32'd0, 1'b1);
    din_vld = 1'b0;
    take("relu_late_ignored", 16'hFFF7);

    // Saturation.
    window(24'h7FFFFF, 32'd0, 1'b0);
    take("sat_pos", 16'h7FFF);
    window(24'h800000, 32'd0, 1'b0);
    take("sat_neg", 16'h8000);

    // Bias and floor rounding.
    window(24'd100, -32'sd512, 1'b0);
    take("bias_neg", 16'h0001);
    feed(-24'sd1, 32'd0, 1'b0);
    for (int i = 0; i < 8; i++) feed(24'd0, 32'd0, 1'b0);
    din_vld = 1'b0;
    take("floor_m1", 16'hFFFF);
    feed(24'd256, 32'd0, 1'b0);
    for (int i = 0; i < 8; i++) feed(24'd256, 32'd12345, 1'b1);
    din_vld = 1'b0;
    take("bias_mid_ignored", 16'h0009);

    // Input gap between taps 4 and 5.
    for (int i = 0; i < 4; i++) feed(24'd256, 32'd0, 1'b0);
    din_vld = 1'b0;
    din     = 24'h7FFFFF;
    step();
    step();
    step();
    for (int i = 0; i < 5; i++) feed(24'd256, 32'd0, 1'b0);
    din_vld = 1'b0;
    take("gap", 16'h0009);

    // Output backpressure: a poisonous din stays valid while stalled.
    dout_rdy = 1'b0;
    for (int i = 0; i < 9; i++) feed(24'd256, 32'd0, 1'b0);
    din = 24'h7FFFFF;
    step();
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_vld", {31'd0, dout_vld}, 32'd1);
      chk("bp_dout", {16'd0, dout}, 32'd9);
      chk("bp_din_rdy", {31'd0, din_rdy}, 32'd0);
    end
    din_vld  = 1'b0;
    dout_rdy = 1'b1;
    step();
    chk("bp_release_vld", {31'd0, dout_vld}, 32'd0);
    chk("bp_release_rdy", {31'd0, din_rdy}, 32'd1);
    window(24'd256, 32'd0, 1'b0);
    take("bp_next_window", 16'h0009);

    // Reset mid-window discards the partial sum.
    for (int i = 0; i < 4; i++) feed(24'h7FFFFF, 32'd0, 1'b0);
    din_vld  = 1'b0;
    ap_rst_n = 1'b0;
    step();
    chk("midrst_vld", {31'd0, dout_vld}, 32'd0);
    chk("midrst_dout", {16'd0, dout}, 32'd0);
    chk("midrst_din_rdy", {31'd0, din_rdy}, 32'd0);
    ap_rst_n = 1'b1;
    for (int i = 0; i < 12; i++) step();
    chk("midrst_no_output", {31'd0, dout_vld}, 32'd0);
    window(24'd256, 32'd0, 1'b0);
    take("midrst_next", 16'h0009);

    // Reset while holding a result drops it.
    dout_rdy = 1'b0;
    window(24'd512, 32'd0, 1'b0);
    step();
    step();
    chk("outrst_pending_vld", {31'd0, dout_vld}, 32'd1);
    chk("outrst_pending_dout", {16'd0, dout}, 32'd18);
    ap_rst_n = 1'b0;
    step();
    chk("outrst_vld", {31'd0, dout_vld}, 32'd0);
    chk("outrst_dout", {16'd0, dout}, 32'd0);
    ap_rst_n = 1'b1;
    dout_rdy = 1'b1;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
